// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default geometry and PC step.
package fetch_queue_defs;

    localparam int unsigned DEPTH_DEFAULT   = 4;
    localparam int unsigned ADDR_W_DEFAULT  = 32;
    localparam int unsigned INSTR_W_DEFAULT = 32;
    localparam int unsigned PC_STEP         = 4;

    function automatic int unsigned entry_width(input int unsigned addr_w, input int unsigned instr_w);
        return addr_w + instr_w;
    endfunction

    localparam int unsigned ENTRY_W_DEFAULT = entry_width(ADDR_W_DEFAULT, INSTR_W_DEFAULT);

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-side push bus, flush/overflow sideband and decode-side head bus of the fetch queue.
interface instruction_fetch_queue_if #(
    parameter int unsigned ADDR_W  = fetch_queue_defs::ADDR_W_DEFAULT,
    parameter int unsigned INSTR_W = fetch_queue_defs::INSTR_W_DEFAULT
);
    logic               fetch_valid;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] fetch_instruction;
    logic               flush;
    logic               fq_full;
    logic               dec_ready;
    logic               dec_valid;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  dec_pc_plus4;
    logic [INSTR_W-1:0] dec_instruction;
    logic               fq_overflow;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instruction, flush, dec_ready,
        output fq_full, dec_valid, dec_pc, dec_pc_plus4, dec_instruction, fq_overflow
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_instruction, flush, dec_ready,
        input  fq_full, dec_valid, dec_pc, dec_pc_plus4, dec_instruction, fq_overflow
    );
endinterface

// File: rtl/instruction_fetch_queue_ptr_ctrl.sv
// Read/write pointers, occupancy count and sticky overflow flag for the fetch queue.
module fq_ptr_ctrl
    import fetch_queue_defs::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic             dec_ready,
    input  logic             flush,
    output logic             push_c,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [CNT_W-1:0] count;
    logic             pop_c;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign push_c = fetch_valid & ~full & ~flush;
    assign pop_c  = ~empty & dec_ready & ~flush;

    // Full refuses a same-cycle push even when a pop frees a slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (fetch_valid && full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch-to-decode decoupling FIFO of (PC, instruction) pairs with flush on redirect.
module instruction_fetch_queue
    import fetch_queue_defs::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned INSTR_W = INSTR_W_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_queue_if.slave  fq
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = entry_width(ADDR_W, INSTR_W);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               full;
    logic               empty;
    logic               overflow;

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fq.fetch_valid),
        .dec_ready   (fq.dec_ready),
        .flush       (fq.flush),
        .push_c      (push),
        .rd_ptr      (rd_ptr),
        .wr_ptr      (wr_ptr),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    // Storage is cleared on reset so the head read is never X.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= {fq.fetch_pc, fq.fetch_instruction};
        end
    end

    assign head               = mem[rd_ptr];
    assign fq.dec_pc          = head[ENTRY_W-1:INSTR_W];
    assign fq.dec_instruction = head[INSTR_W-1:0];
    assign fq.dec_pc_plus4    = head[ENTRY_W-1:INSTR_W] + ADDR_W'(PC_STEP);
    assign fq.dec_valid       = ~empty;
    assign fq.fq_full         = full;
    assign fq.fq_overflow     = overflow;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench: vector table, hand-written corner sequences and a random run against a queue model.
module tb_instruction_fetch_queue;
    import fetch_queue_defs::*;

    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    instruction_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) fq ();

    instruction_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .fq    (fq.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: an unbounded queue trimmed by the occupancy rules, plus a sticky flag.
    logic [63:0] mq [$];
    bit          m_ovf = 1'b0;

    typedef struct {
        bit          fv;
        logic [31:0] pc;
        bit          fl;
        bit          rdy;
        bit          ev;
        bit          ef;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit fv, input logic [31:0] pc, input logic [31:0] instr,
                         input bit fl, input bit rdy);
        fq.fetch_valid       = fv;
        fq.fetch_pc          = pc;
        fq.fetch_instruction = instr;
        fq.flush             = fl;
        fq.dec_ready         = rdy;
    endtask

    task automatic tick();
        bit was_full;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (fq.flush) begin
            mq.delete();
        end else begin
            was_full = (mq.size() == DEPTH);
            if (fq.fetch_valid && was_full) m_ovf = 1'b1;
            if (mq.size() != 0 && fq.dec_ready) void'(mq.pop_front());
            if (fq.fetch_valid && !was_full) mq.push_back({fq.fetch_pc, fq.fetch_instruction});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] hpc;
        chk({tag, "_valid"}, 32'(fq.dec_valid), 32'(mq.size() != 0));
        chk({tag, "_full"},  32'(fq.fq_full),   32'(mq.size() == DEPTH));
        chk({tag, "_ovf"},   32'(fq.fq_overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            hpc = mq[0][63:32];
            chk({tag, "_pc"},    fq.dec_pc, hpc);
            chk({tag, "_instr"}, fq.dec_instruction, mq[0][31:0]);
            chk({tag, "_plus4"}, fq.dec_pc_plus4, hpc + 32'd4);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Fill/drain, flush at count 3 with push+pop, then redirect target, then PC wrap.
        tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[2]  = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[3]  = '{1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0004};
        tbl[5]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008};
        tbl[6]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_000C};
        tbl[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        tbl[8]  = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
        tbl[9]  = '{1'b1, 32'h0000_0024, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
        tbl[10] = '{1'b1, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
        tbl[11] = '{1'b1, 32'h0000_002C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        tbl[12] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        tbl[14] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
        tbl[15] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};

        // Reset then idle.
        do_reset();
        chk("rst_valid", 32'(fq.dec_valid), 32'd0);
        chk("rst_full",  32'(fq.fq_full), 32'd0);
        chk("rst_ovf",   32'(fq.fq_overflow), 32'd0);
        chk("rst_pc",    fq.dec_pc, 32'd0);
        chk("rst_plus4", fq.dec_pc_plus4, 32'd4);
        chk("rst_instr", fq.dec_instruction, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].fv, tbl[i].pc, tbl[i].pc ^ 32'hA5A5_0000, tbl[i].fl, tbl[i].rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(fq.dec_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_full", i),  32'(fq.fq_full),   32'(tbl[i].ef));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_pc", i),    fq.dec_pc, tbl[i].epc);
                chk($sformatf("vec%0d_plus4", i), fq.dec_pc_plus4, tbl[i].epc + 32'd4);
                chk($sformatf("vec%0d_instr", i), fq.dec_instruction, tbl[i].epc ^ 32'hA5A5_0000);
            end
        end

        // Continuous push+pop at count 2 across pointer wrap.
        do_reset();
        drive(1'b1, 32'h0000_00A0, 32'h1111_00A0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0000_00A4, 32'h1111_00A4, 1'b0, 1'b0); tick();
        check_model("pp_pre");
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h0000_00A8 + 32'(4 * i), 32'h1111_00A8 + 32'(4 * i), 1'b0, 1'b1);
            tick();
            check_model($sformatf("pp%0d", i));
            chk($sformatf("pp%0d_head", i), fq.dec_pc, 32'h0000_00A4 + 32'(4 * i));
        end

        // Overflow: dropped entry, sticky through flush, cleared by reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0200 + 32'(4 * i), 32'h2222_0000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick();
        check_model("ovf_set");
        chk("ovf_flag", 32'(fq.fq_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            tick();
            check_model($sformatf("ovf_drain%0d", i));
        end
        chk("ovf_drop_empty", 32'(fq.dec_valid), 32'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk("ovf_after_flush", 32'(fq.fq_overflow), 32'd1);
        do_reset();
        chk("ovf_after_reset", 32'(fq.fq_overflow), 32'd0);

        // Random traffic against the model, with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC, $urandom(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            tick();
            check_model($sformatf("rnd%0d", i));
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Decoupling buffer between instruction fetch and decode. It captures each (PC, instruction) pair produced by fetch into a small synchronous FIFO and presents the oldest entry to decode under a valid/ready handshake. It back-pressures fetch through `fq_full`, which fetch ORs into its busywait. It discards all buffered entries when a branch or jump redirects the PC.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `ADDR_W`, 32: PC width.
- `INSTR_W`, 32: instruction width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_valid`  in  1  fetch presents a new pair this cycle (fetch PC advanced and instruction-memory busywait low).
- `fetch_pc`  in  ADDR_W  PC of the presented instruction.
- `fetch_instruction`  in  INSTR_W  instruction word.
- `flush`  in  1  `branch_or_jump_signal` from execute; kills all queued and incoming entries.
- `fq_full`  out  1  queue holds DEPTH entries; fetch must stall.
- `dec_ready`  in  1  decode consumes the head entry this cycle.
- `dec_valid`  out  1  head entry is valid.
- `dec_pc`  out  ADDR_W  head PC.
- `dec_pc_plus4`  out  ADDR_W  head PC + 4.
- `dec_instruction`  out  INSTR_W  head instruction.
- `fq_overflow`  out  1  sticky error: push attempted while full.

## Operation
- Storage: DEPTH entries of {pc, instruction}, with read pointer `rd_ptr`, write pointer `wr_ptr` (log2(DEPTH) bits each, natural wrap-around), and `count` (log2(DEPTH)+1 bits).
- `push` = `fetch_valid` & ~`fq_full` & ~`flush`.
- `pop` = `dec_valid` & `dec_ready` & ~`flush`.
- Push only: write the entry at `wr_ptr`, then `wr_ptr`+1 and `count`+1.
- Pop only: `rd_ptr`+1 and `count`-1.
- Push and pop in the same cycle (count in 1..DEPTH-1): both pointers advance and `count` is unchanged.
- Full with push and pop in the same cycle: the push is refused because `fq_full` is already high (no write-through-on-pop).
- Empty with pop: impossible, since `dec_valid` is low.
- `fetch_valid` while full and not flushing: the entry is dropped and `fq_overflow` is set. It is cleared only by `reset`.
- `flush`: `rd_ptr`, `wr_ptr` and `count` are set to 0 and any same-cycle push or pop is ignored. `fq_overflow` is unaffected.
- Priority: `reset` > `flush` > push/pop.
- No bypass: an empty queue never forwards fetch inputs straight to the decode outputs.
- `dec_valid` = (`count` != 0).
- `dec_pc` and `dec_instruction` are a combinational read of the entry at `rd_ptr`. They are don't-care when `dec_valid` is low, but must not be X after reset.
- `dec_pc_plus4` = `dec_pc` + 4, modulo 2^ADDR_W (so 0xFFFFFFFC + 4 = 0x00000000).
- `fq_full` = (`count` == DEPTH).

## Timing
- Reset values after the reset edge:
  - `dec_valid`=0, `fq_full`=0, `fq_overflow`=0.
  - `dec_pc`=0, `dec_pc_plus4`=4, `dec_instruction`=0 (storage cleared to 0).
- Latency: an entry pushed at edge N is visible on `dec_*` with `dec_valid`=1 after edge N. Empty-to-decode latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- `fq_full` rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop.
- Flush takes effect at the edge where `flush`=1. The next cycle shows `dec_valid`=0 and `fq_full`=0. The first post-flush push (the branch target) is visible one cycle later.
- Reset asserted mid-operation, including during a flush, clears all state at that edge, overflow included.

## Structure
- Shared package / include `fetch_queue_defs`:
  - entry field widths and total entry width (ADDR_W+INSTR_W);
  - the `DEPTH` default;
  - the `PC_STEP` constant, 4.
- One sub-module, `fq_ptr_ctrl`: pointer/count/full/empty logic, parameterised on DEPTH.
- Entry storage and the read mux stay in the top module.

## Test plan
- Reset then idle:
  - Stimulus: reset held 2 cycles, then released.
  - Required: `dec_valid`=0, `fq_full`=0, `dec_pc_plus4`=4, `fq_overflow`=0.
- Fill and drain, DEPTH=4:
  - Stimulus: push PCs 0x00, 0x04, 0x08, 0x0C with `dec_ready`=0; then `dec_ready`=1.
  - Required: `fq_full`=1 after the 4th edge. Outputs drain in order 0x00 → 0x0C, one per cycle. `dec_valid` falls after the 4th pop.
- Simultaneous push/pop at count=2:
  - Required: `count` stays 2 and order is preserved across `wr_ptr` wrap, with 6 continuous pushes and pops.
- Overflow:
  - Stimulus: `fetch_valid`=1 while full.
  - Required: entry dropped, `fq_overflow`=1 and sticky. A later flush leaves it set; reset clears it.
- Flush with simultaneous push and pop at count=3:
  - Required: next cycle `dec_valid`=0. A push of target PC 0x100 appears with `dec_pc_plus4`=0x104 one cycle later.
- PC wrap:
  - Stimulus: push PC 0xFFFFFFFC.
  - Required: `dec_pc_plus4`=0x00000000.
